c2_window_read: RTL and testbench

C2_WINDOW_READ -- requirements
Module: c2_window_read

---
 rtl/c2_window_read_pkg.sv | 9 +
 rtl/c2_window_read_if.sv | 25 ++
 rtl/c2_window_read_tap_counter.sv | 69 ++++++
 rtl/c2_window_read.sv | 74 +++++++
 tb/tb_c2_window_read.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/c2_window_read_pkg.sv
// Shared CNN constants and the conv-2 window-read state encoding.
package c2_window_read_pkg;
  localparam int C2_IMG_W = 12;
  localparam int C2_K     = 5;
  localparam int C2_OUT_W = C2_IMG_W - C2_K + 1;
  localparam int C2_AW    = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} state_t;
endpackage

// File: rtl/c2_window_read_if.sv
// Handshake bundle between the conv-2 window reader and the MAC/memory side.
interface c2_window_read_if #(parameter int AW = 8);
  logic          start;
  logic          ready;
  logic [AW-1:0] addr;
  logic          addr_valid;
  logic          tap_first;
  logic          tap_last;
  logic          data_valid;
  logic          data_last;
  logic [5:0]    out_idx;
  logic          busy;
  logic          done;

  modport master (
    input  start, ready,
    output addr, addr_valid, tap_first, tap_last,
           data_valid, data_last, out_idx, busy, done
  );
  modport slave (
    output start, ready,
    input  addr, addr_valid, tap_first, tap_last,
           data_valid, data_last, out_idx, busy, done
  );
endinterface

// File: rtl/c2_window_read_tap_counter.sv
// Nested tap/window counters with multiplier-free address generation.
module c2_tap_counter #(
  parameter int IMG_W = 12,
  parameter int K     = 5,
  parameter int AW    = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clr,
  input  logic                            adv,
  output logic [$clog2(IMG_W-K+1)-1:0]    oc,
  output logic [$clog2(IMG_W-K+1)-1:0]    orow,
  output logic [AW-1:0]                   addr,
  output logic                            first_tap,
  output logic                            last_tap,
  output logic                            scan_end
);
  localparam int OUT_W = IMG_W - K + 1;
  localparam int KW    = $clog2(K);
  localparam int OW    = $clog2(OUT_W);

  logic [KW-1:0] kc, kr;
  // win_base: address of tap (0,0) of the current window; row_base adds kr rows
  logic [AW-1:0] win_base, row_base;

  assign addr      = row_base + AW'(kc);
  assign first_tap = (kc == '0) && (kr == '0);
  assign last_tap  = (kc == KW'(K-1)) && (kr == KW'(K-1));
  assign scan_end  = last_tap && (oc == OW'(OUT_W-1)) && (orow == OW'(OUT_W-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kc <= '0; kr <= '0; oc <= '0; orow <= '0;
      win_base <= '0; row_base <= '0;
    end else if (clr) begin
      kc <= '0; kr <= '0; oc <= '0; orow <= '0;
      win_base <= '0; row_base <= '0;
    end else if (adv) begin
      if (kc != KW'(K-1)) begin
        kc <= kc + 1'b1;
      end else begin
        kc <= '0;
        if (kr != KW'(K-1)) begin
          kr       <= kr + 1'b1;
          row_base <= row_base + AW'(IMG_W);
        end else begin
          kr <= '0;
          if (oc != OW'(OUT_W-1)) begin
            oc       <= oc + 1'b1;
            win_base <= win_base + 1'b1;
            row_base <= win_base + 1'b1;
          end else begin
            oc <= '0;
            // last column of a window row: step back OUT_W-1 and down one row
            if (orow != OW'(OUT_W-1)) begin
              orow     <= orow + 1'b1;
              win_base <= win_base + AW'(K);
              row_base <= win_base + AW'(K);
            end else begin
              orow     <= '0;
              win_base <= '0;
              row_base <= '0;
            end
          end
        end
      end
    end
  end
endmodule

// File: rtl/c2_window_read.sv
// Conv-2 window reader: scans every KxK window of the pooled-1 image in raster order.
module c2_window_read
  import c2_window_read_pkg::*;
#(
  parameter int IMG_W = C2_IMG_W,
  parameter int K     = C2_K,
  parameter int AW    = C2_AW
) (
  input  logic             clk,
  input  logic             reset,
  c2_window_read_if.master bus
);
  localparam int OUT_W = IMG_W - K + 1;
  localparam int OW    = $clog2(OUT_W);

  state_t state, nxt;
  logic [OW-1:0] oc, orow;
  logic [AW-1:0] addr;
  logic first_tap, last_tap, scan_end;
  logic run, accept, clr;

  assign run    = (state == ST_RUN);
  assign accept = run && bus.ready;
  assign clr    = bus.start && ((state == ST_IDLE) || (state == ST_DONE));

  c2_tap_counter #(.IMG_W(IMG_W), .K(K), .AW(AW)) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .adv       (accept),
    .oc        (oc),
    .orow      (orow),
    .addr      (addr),
    .first_tap (first_tap),
    .last_tap  (last_tap),
    .scan_end  (scan_end)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (bus.start) nxt = ST_RUN;
      ST_RUN:   if (accept && scan_end) nxt = ST_FLUSH;
      ST_FLUSH: nxt = ST_DONE;
      ST_DONE:  if (bus.start) nxt = ST_RUN;
      default:  nxt = ST_IDLE;
    endcase
  end

  // memory has one cycle of read latency, so the tap tags ride one register behind
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.data_valid <= 1'b0;
      bus.data_last  <= 1'b0;
      bus.out_idx    <= '0;
    end else begin
      bus.data_valid <= accept;
      bus.data_last  <= accept && last_tap;
      if (accept) bus.out_idx <= 6'(orow * OUT_W + oc);
    end
  end

  assign bus.addr       = addr;
  assign bus.addr_valid = run;
  assign bus.tap_first  = run && first_tap;
  assign bus.tap_last   = run && last_tap;
  assign bus.busy       = run || (state == ST_FLUSH);
  assign bus.done       = (state == ST_DONE);
endmodule

// File: tb/tb_c2_window_read.sv
// Directed bench for c2_window_read: tap order, full scan, stall, reset, start handling.
module tb_c2_window_read;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;

  c2_window_read_if #(.AW(8)) bus ();

  c2_window_read dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // expected address of the t-th accepted tap: window w = t/25 in raster order
  function automatic logic [7:0] exp_addr(input int t);
    int w, j;
    w = t / 25;
    j = t % 25;
    return 8'(((w / 8) + (j / 5)) * 12 + (w % 8) + (j % 5));
  endfunction

  function automatic logic exp_first(input int t);
    return (t % 25) == 0;
  endfunction

  function automatic logic exp_last(input int t);
    return (t % 25) == 24;
  endfunction

  task automatic pulse_start;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_reset;
    bus.start = 1'b0;
    bus.ready = 1'b0;
    reset = 1'b0;
    #12;
    total++;
    if ({bus.addr, bus.addr_valid, bus.tap_first, bus.tap_last, bus.data_valid,
         bus.data_last, bus.out_idx, bus.busy, bus.done} !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs: got addr=%h av=%b tf=%b tl=%b dv=%b dl=%b idx=%0d busy=%b done=%b want all 0",
               bus.addr, bus.addr_valid, bus.tap_first, bus.tap_last, bus.data_valid,
               bus.data_last, bus.out_idx, bus.busy, bus.done);
    end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_first_window;
    bus.ready = 1'b1;
    pulse_start();
    for (int t = 0; t < 26; t++) begin
      total++;
      if ({bus.addr, bus.addr_valid, bus.tap_first, bus.tap_last, bus.data_valid, bus.data_last} !==
          {exp_addr(t), 1'b1, exp_first(t), exp_last(t), (t > 0), (t == 25)}) begin
        bad++;
        $display("FAIL first_window t=%0d: got addr=%0d av=%b tf=%b tl=%b dv=%b dl=%b want addr=%0d tf=%b tl=%b",
                 t, bus.addr, bus.addr_valid, bus.tap_first, bus.tap_last, bus.data_valid,
                 bus.data_last, exp_addr(t), exp_first(t), exp_last(t));
      end
      @(negedge clk);
    end
    do_reset();
  endtask

  task automatic test_full_scan;
    int t = 0;
    int lasts = 0;
    int cyc = 0;
    logic [7:0] last_addr = '0;
    bus.ready = 1'b1;
    pulse_start();
    while (t < 1600 && cyc < 3000) begin
      if (bus.data_valid && bus.data_last) begin
        total++;
        if (bus.out_idx !== 6'(lasts)) begin
          bad++;
          $display("FAIL scan_out_idx: got %0d want %0d", bus.out_idx, lasts);
        end
        lasts++;
      end
      if (bus.addr_valid && bus.ready) begin
        total++;
        if (bus.addr !== exp_addr(t)) begin
          bad++;
          $display("FAIL scan_addr t=%0d: got %0d want %0d", t, bus.addr, exp_addr(t));
        end
        last_addr = bus.addr;
        t++;
      end
      @(negedge clk);
      cyc++;
    end
    total++;
    if (t != 1600) begin
      bad++;
      $display("FAIL scan_accepts: got %0d want 1600 (cycle budget)", t);
    end
    total++;
    if (last_addr !== 8'd143) begin
      bad++;
      $display("FAIL scan_last_addr: got %0d want 143", last_addr);
    end
    // flush cycle: final data beat, not yet done
    total++;
    if ({bus.busy, bus.done, bus.addr_valid, bus.data_valid, bus.data_last, bus.out_idx} !==
        {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd63}) begin
      bad++;
      $display("FAIL scan_flush: got busy=%b done=%b av=%b dv=%b dl=%b idx=%0d want 1 0 0 1 1 63",
               bus.busy, bus.done, bus.addr_valid, bus.data_valid, bus.data_last, bus.out_idx);
    end
    if (bus.data_valid && bus.data_last) lasts++;
    total++;
    if (lasts != 64) begin
      bad++;
      $display("FAIL scan_data_last_count: got %0d want 64", lasts);
    end
    @(negedge clk);
    total++;
    if ({bus.busy, bus.done, bus.data_valid, bus.addr_valid} !== 4'b0100) begin
      bad++;
      $display("FAIL scan_done: got busy=%b done=%b dv=%b av=%b want 0 1 0 0",
               bus.busy, bus.done, bus.data_valid, bus.addr_valid);
    end
    repeat (3) @(negedge clk);
    total++;
    if (bus.done !== 1'b1) begin
      bad++;
      $display("FAIL done_sticky: got %b want 1", bus.done);
    end
  endtask

  // entered from DONE: restart, then a start pulse mid-run must be ignored
  task automatic test_start_handling;
    bus.ready = 1'b1;
    pulse_start();
    total++;
    if ({bus.done, bus.busy, bus.addr, bus.tap_first} !== {1'b0, 1'b1, 8'd0, 1'b1}) begin
      bad++;
      $display("FAIL restart_from_done: got done=%b busy=%b addr=%0d tf=%b want 0 1 0 1",
               bus.done, bus.busy, bus.addr, bus.tap_first);
    end
    for (int t = 0; t < 11; t++) begin
      total++;
      if ({bus.addr, bus.tap_first, bus.tap_last} !== {exp_addr(t), exp_first(t), exp_last(t)}) begin
        bad++;
        $display("FAIL start_in_run t=%0d: got addr=%0d tf=%b tl=%b want addr=%0d",
                 t, bus.addr, bus.tap_first, bus.tap_last, exp_addr(t));
      end
      bus.start = (t == 3);
      @(negedge clk);
    end
    bus.start = 1'b0;
    do_reset();
  endtask

  task automatic test_stall;
    bus.ready = 1'b1;
    pulse_start();
    for (int t = 0; t < 6; t++) @(negedge clk);
    total++;
    if (bus.addr !== 8'd13) begin
      bad++;
      $display("FAIL stall_pre: got addr=%0d want 13", bus.addr);
    end
    bus.ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      total++;
      if ({bus.addr, bus.data_valid, bus.addr_valid, bus.tap_first} !== {8'd13, 1'b0, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL stall_hold s=%0d: got addr=%0d dv=%b av=%b tf=%b want 13 0 1 0",
                 s, bus.addr, bus.data_valid, bus.addr_valid, bus.tap_first);
      end
    end
    bus.ready = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.addr, bus.data_valid} !== {8'd14, 1'b1}) begin
      bad++;
      $display("FAIL stall_resume: got addr=%0d dv=%b want 14 1", bus.addr, bus.data_valid);
    end
    do_reset();
  endtask

  task automatic test_reset_mid;
    bus.ready = 1'b1;
    pulse_start();
    repeat (700) @(negedge clk);
    total++;
    if (bus.addr !== exp_addr(700)) begin
      bad++;
      $display("FAIL mid_addr: got %0d want %0d", bus.addr, exp_addr(700));
    end
    reset = 1'b0;
    #1;
    total++;
    if ({bus.addr, bus.addr_valid, bus.tap_first, bus.tap_last, bus.data_valid,
         bus.data_last, bus.out_idx, bus.busy, bus.done} !== 20'h0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got addr=%0d av=%b dv=%b idx=%0d busy=%b want all 0",
               bus.addr, bus.addr_valid, bus.data_valid, bus.out_idx, bus.busy);
    end
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.data_valid, bus.addr_valid, bus.busy} !== 3'b000) begin
      bad++;
      $display("FAIL post_reset_idle: got dv=%b av=%b busy=%b want 0 0 0",
               bus.data_valid, bus.addr_valid, bus.busy);
    end
    pulse_start();
    total++;
    if ({bus.addr, bus.tap_first, bus.addr_valid} !== {8'd0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL post_reset_start: got addr=%0d tf=%b av=%b want 0 1 1",
               bus.addr, bus.tap_first, bus.addr_valid);
    end
  endtask

  initial begin
    test_reset();
    test_first_window();
    test_full_scan();
    test_start_handling();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
